// File: rtl/pwm_main.sv
// pwm_main: write-only SPI slave that programs four 8-bit PWM channels.
// SPI pins are oversampled by CLK; SCLK is treated as data, never as a clock.
module pwm_main (
  input  logic       CLK,
  input  logic       _RST,
  input  logic       _CS,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       EN,
  output logic       MISO,
  output logic [3:0] PWMOutputs
);

  localparam int unsigned NCH = 4;

  logic [1:0] cs_sync;
  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic       sclk_prev;
  logic       cs_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       sclk_rise;

  always_ff @(posedge CLK or posedge _RST) begin
    if (_RST) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], _CS};
      sclk_sync <= {sclk_sync[0], SCLK};
      mosi_sync <= {mosi_sync[0], MOSI};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign cs_q      = cs_sync[1];
  assign sclk_q    = sclk_sync[1];
  assign mosi_q    = mosi_sync[1];
  assign sclk_rise = sclk_q & ~sclk_prev;

  // Only the last ten bits are kept: address bits [7:3] are dropped on the fly.
  logic [3:0] bit_cnt;
  logic [9:0] shift_q;
  logic       wr_stb;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  assign wr_stb  = ~cs_q & sclk_rise & (bit_cnt == 4'd15);
  assign wr_addr = shift_q[9:7];
  assign wr_data = {shift_q[6:0], mosi_q};

  always_ff @(posedge CLK or posedge _RST) begin
    if (_RST) begin
      bit_cnt <= 4'd0;
      shift_q <= 10'd0;
    end else if (cs_q) begin
      bit_cnt <= 4'd0;
      shift_q <= 10'd0;
    end else if (sclk_rise) begin
      bit_cnt <= bit_cnt + 4'd1;
      shift_q <= {shift_q[8:0], mosi_q};
    end
  end

  logic [NCH-1:0][7:0] duty_q;
  logic [NCH-1:0][7:0] duty_nxt;
  logic [7:0]          period_q;
  logic [7:0]          period_nxt;
  logic [7:0]          prescale_q;
  logic [7:0]          prescale_nxt;

  always_comb begin
    duty_nxt     = duty_q;
    period_nxt   = period_q;
    prescale_nxt = prescale_q;
    if (wr_stb) begin
      case (wr_addr)
        3'd0, 3'd1, 3'd2, 3'd3: duty_nxt[wr_addr[1:0]] = wr_data;
        3'd4:                   period_nxt             = wr_data;
        3'd5:                   prescale_nxt           = wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge _RST) begin
    if (_RST) begin
      duty_q     <= '0;
      period_q   <= 8'hFF;
      prescale_q <= 8'h00;
    end else begin
      duty_q     <= duty_nxt;
      period_q   <= period_nxt;
      prescale_q <= prescale_nxt;
    end
  end

  logic [7:0] presc_cnt;
  logic       tick;

  assign tick = EN & (presc_cnt == 8'd0);

  always_ff @(posedge CLK or posedge _RST) begin
    if (_RST) begin
      presc_cnt <= 8'd0;
    end else if (!EN) begin
      presc_cnt <= 8'd0;
    end else if (presc_cnt == 8'd0) begin
      presc_cnt <= prescale_q;
    end else begin
      presc_cnt <= presc_cnt - 8'd1;
    end
  end

  logic [7:0]          pwm_cnt;
  logic [NCH-1:0][7:0] duty_sh;
  logic [7:0]          period_sh;
  logic                wrap;

  assign wrap = tick & (pwm_cnt == period_sh);

  always_ff @(posedge CLK or posedge _RST) begin
    if (_RST) begin
      pwm_cnt <= 8'd0;
    end else if (!EN) begin
      pwm_cnt <= 8'd0;
    end else if (wrap) begin
      pwm_cnt <= 8'd0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Shadows take the *_nxt values so a write landing on the wrap cycle is not lost.
  always_ff @(posedge CLK or posedge _RST) begin
    if (_RST) begin
      duty_sh   <= '0;
      period_sh <= 8'hFF;
    end else if (!EN || wrap) begin
      duty_sh   <= duty_nxt;
      period_sh <= period_nxt;
    end
  end

  logic [NCH-1:0] cmp;

  always_comb begin
    cmp = '0;
    for (int n = 0; n < NCH; n++) begin
      cmp[n] = (pwm_cnt < duty_sh[n]);
    end
  end

  always_ff @(posedge CLK or posedge _RST) begin
    if (_RST) begin
      PWMOutputs <= 4'b0000;
    end else begin
      PWMOutputs <= EN ? cmp : 4'b0000;
    end
  end

  assign MISO = 1'b0;

endmodule

// File: tb/tb_pwm_main.sv
// Bench for pwm_main: cycle-level reference model feeding a scoreboard queue,
// plus directed duty-cycle measurements over whole periods.
`timescale 1ns/1ps
module tb_pwm_main;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       en   = 1'b0;
  logic       miso;
  logic [3:0] pwm;

  int errors = 0;
  int checks = 0;

  pwm_main dut (
    .CLK        (clk),
    ._RST       (rst),
    ._CS        (cs_n),
    .SCLK       (sclk),
    .MOSI       (mosi),
    .EN         (en),
    .MISO       (miso),
    .PWMOutputs (pwm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: programmed registers, values in force for the current
  // period, position in the period, and cycles left until the next step.
  logic [7:0] m_duty[4];
  logic [7:0] m_per;
  logic [7:0] m_pre;
  logic [7:0] s_duty[4];
  logic [7:0] s_per;
  int         m_pos;
  int         m_wait;
  bit         h_cs[3];
  bit         h_sclk[3];
  bit         h_mosi[3];
  int         m_bits;
  logic [15:0] m_word;
  logic [3:0] exp_q[$];

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_duty[c] = 8'h00;
      s_duty[c] = 8'h00;
    end
    m_per  = 8'hFF;
    s_per  = 8'hFF;
    m_pre  = 8'h00;
    m_pos  = 0;
    m_wait = 0;
    m_bits = 0;
    m_word = 16'h0;
    for (int j = 0; j < 3; j++) begin
      h_cs[j]   = 1'b1;
      h_sclk[j] = 1'b0;
      h_mosi[j] = 1'b0;
    end
  endtask

  logic [7:0] nduty[4];
  logic [7:0] nper, npre;
  logic [3:0] e;
  bit         commit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      exp_q.delete();
    end else begin
      // pins reach the core two samples late; a rise is seen one sample later still
      commit = 1'b0;
      if (h_cs[1]) begin
        m_bits = 0;
        m_word = 16'h0;
      end else if (h_sclk[1] && !h_sclk[2]) begin
        m_word = {m_word[14:0], h_mosi[1]};
        m_bits++;
        if (m_bits == 16) begin
          commit = 1'b1;
          m_bits = 0;
        end
      end
      nduty = m_duty;
      nper  = m_per;
      npre  = m_pre;
      if (commit) begin
        if (m_word[10:8] < 3'd4) nduty[m_word[9:8]] = m_word[7:0];
        else if (m_word[10:8] == 3'd4) nper = m_word[7:0];
        else if (m_word[10:8] == 3'd5) npre = m_word[7:0];
      end
      for (int c = 0; c < 4; c++) e[c] = en && (m_pos < int'(s_duty[c]));
      exp_q.push_back(e);
      if (!en) begin
        m_pos  = 0;
        m_wait = 0;
        s_duty = nduty;
        s_per  = nper;
      end else if (m_wait == 0) begin
        m_wait = int'(m_pre);
        if (m_pos == int'(s_per)) begin
          m_pos  = 0;
          s_duty = nduty;
          s_per  = nper;
        end else begin
          m_pos++;
        end
      end else begin
        m_wait--;
      end
      m_duty = nduty;
      m_per  = nper;
      m_pre  = npre;
      h_cs[2] = h_cs[1];     h_cs[1] = h_cs[0];     h_cs[0] = cs_n;
      h_sclk[2] = h_sclk[1]; h_sclk[1] = h_sclk[0]; h_sclk[0] = sclk;
      h_mosi[2] = h_mosi[1]; h_mosi[1] = h_mosi[0]; h_mosi[0] = mosi;
    end
  end

  logic [3:0] got_e;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_out", {28'd0, pwm}, 32'd0);
    end else begin
      while (exp_q.size() > 0) begin
        got_e = exp_q.pop_front();
        check("pwm_out", {28'd0, pwm}, {28'd0, got_e});
      end
      check("miso", {31'd0, miso}, 32'd0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [31:0] w, input int n, input bit release_cs);
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = w[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
    if (release_cs) begin
      cs_n = 1'b1;
      wait_clk(4);
    end
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    spi_bits({16'h0, a, d}, 16, 1'b1);
  endtask

  int hc[4];

  task automatic count_high(input int n);
    for (int c = 0; c < 4; c++) hc[c] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (pwm[c]) hc[c]++;
    end
  endtask

  logic [7:0] ra, rd;
  int         op;

  initial begin
    model_reset();
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    check("reset_pwm", {28'd0, pwm}, 32'd0);
    check("reset_miso", {31'd0, miso}, 32'd0);

    // 50% duty on channel 0 at full period
    en = 1'b1;
    spi_write(8'h00, 8'h80);
    wait_clk(300);
    count_high(256);
    check("duty80_ch0", hc[0], 128);
    check("duty80_ch1", hc[1], 0);
    check("duty80_ch3", hc[3], 0);

    // short period with prescale
    spi_write(8'h04, 8'h09);
    spi_write(8'h05, 8'h01);
    spi_write(8'h02, 8'h03);
    wait_clk(600);
    count_high(20);
    check("p9_ch2_high", hc[2], 6);
    check("p9_ch0_const", hc[0], 20);
    count_high(40);
    check("p9_ch2_2per", hc[2], 12);
    spi_write(8'h02, 8'h0A);
    wait_clk(60);
    count_high(20);
    check("duty_gt_per", hc[2], 20);

    // back to full period, then change duty mid-period
    spi_write(8'h04, 8'hFF);
    spi_write(8'h05, 8'h00);
    wait_clk(300);
    wait_clk(100);
    spi_write(8'h00, 8'h20);
    wait_clk(300);
    count_high(256);
    check("glitch_ch0", hc[0], 32);

    // partial frame is discarded, 32-bit burst is two writes
    spi_bits(32'h0155 >> 7, 9, 1'b1);
    spi_bits(32'h0140_03C0, 32, 1'b1);
    wait_clk(300);
    count_high(256);
    check("burst_ch0", hc[0], 32);
    check("burst_ch1", hc[1], 64);
    check("burst_ch2", hc[2], 10);
    check("burst_ch3", hc[3], 192);

    // enable drop and restart
    wait_clk(77);
    en = 1'b0;
    @(negedge clk);
    check("en_low_out", {28'd0, pwm}, 32'd0);
    wait_clk(10);
    en = 1'b1;
    @(negedge clk);
    check("en_restart", {28'd0, pwm}, 32'hF);
    count_high(256);
    check("en_ch1", hc[1], 64);

    // reset mid-frame and mid-period
    wait_clk(5);
    spi_bits(32'h55, 7, 1'b0);
    #2 rst = 1'b1;
    #1 check("rst_async", {28'd0, pwm}, 32'd0);
    cs_n = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    spi_write(8'h00, 8'h80);
    wait_clk(300);
    count_high(256);
    check("post_rst_ch0", hc[0], 128);
    check("post_rst_ch1", hc[1], 0);

    // randomized traffic against the model
    spi_write(8'h04, 8'd25);
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 9));
      if (op < 6 || op == 8) begin
        ra = {5'($urandom), 3'($urandom_range(0, 7))};
        case (ra[2:0])
          3'd0, 3'd1, 3'd2, 3'd3: rd = 8'($urandom_range(0, 40));
          3'd4:                   rd = 8'($urandom_range(0, 30));
          3'd5:                   rd = 8'($urandom_range(0, 3));
          default:                rd = 8'($urandom);
        endcase
        if (op == 8) spi_bits({ra, rd, 8'h01, 8'($urandom_range(0, 40))}, 32, 1'b1);
        else spi_write(ra, rd);
      end else if (op == 6) begin
        en = ~en;
      end else if (op == 7) begin
        spi_bits($urandom, int'($urandom_range(1, 15)), 1'b1);
      end
      wait_clk(int'($urandom_range(0, 80)));
    end
    en = 1'b1;
    wait_clk(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
